// File: rtl/instr_align_buffer_if.sv
// Fetch-to-decode bus for instr_align_buffer: the fetch word handshake, the redirect request
// and the registered instruction output slot.
interface instr_align_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            word_valid_i;
  logic            word_ready_o;
  logic [31:0]     word_i;
  logic [XLEN-1:0] word_pc_i;
  logic            word_err_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_comp_o;
  logic            instr_err_o;

  modport slave (
    input  word_valid_i, word_i, word_pc_i, word_err_i, redirect_i, redirect_pc_i, instr_ready_i,
    output word_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_comp_o, instr_err_o
  );

  modport master (
    output word_valid_i, word_i, word_pc_i, word_err_i, redirect_i, redirect_pc_i, instr_ready_i,
    input  word_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_comp_o, instr_err_o
  );
endinterface

// File: rtl/instr_align_buffer.sv
// Splits word-aligned fetch words into 16/32-bit instructions with exact halfword PCs.
// Compressed support is built only when ALIGN_COMP_EN is defined; otherwise it faults.
module instr_align_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_align_buffer_if.slave bus
);

`ifdef ALIGN_COMP_EN
  typedef enum logic [1:0] {StAligned, StHalf, StSkip, StHalt} state_e;
`else
  typedef enum logic [1:0] {StAligned, StMisalign, StHalt} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] exp_wpc_q, exp_wpc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_err_q, instr_err_d;
`ifdef ALIGN_COMP_EN
  logic            instr_comp_q, instr_comp_d;
  logic [15:0]     hw_q, hw_d;
  logic            hw_comp;
  logic [XLEN-1:0] hw_pc;
  logic            emit_comp;
`endif

  logic            adv;
  logic            word_match;
  logic            word_ready;
  logic            take;
  logic            emit;
  logic [31:0]     emit_instr;
  logic [XLEN-1:0] emit_pc;
  logic            emit_err;
  logic            unused_redirect_pc0;

  assign adv                 = ~instr_valid_q | bus.instr_ready_i;
  assign word_match          = (bus.word_pc_i == exp_wpc_q);
  assign unused_redirect_pc0 = bus.redirect_pc_i[0];

`ifdef ALIGN_COMP_EN
  assign hw_comp = (hw_q[1:0] != 2'b11);
  // The held halfword always sits just below the next expected word.
  assign hw_pc   = exp_wpc_q - XLEN'(2);
`endif

  always_comb begin
    state_d       = state_q;
    exp_wpc_d     = exp_wpc_q;
    instr_valid_d = instr_valid_q & ~bus.instr_ready_i;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_err_d   = instr_err_q;
    word_ready    = 1'b0;
    take          = 1'b0;
    emit          = 1'b0;
    emit_instr    = '0;
    emit_pc       = '0;
    emit_err      = 1'b0;
`ifdef ALIGN_COMP_EN
    instr_comp_d  = instr_comp_q;
    hw_d          = hw_q;
    emit_comp     = 1'b0;

    unique case (state_q)
      StAligned: begin
        word_ready = adv;
        take       = bus.word_valid_i & word_ready & word_match;
        if (take) begin
          emit = 1'b1;
          if (bus.word_err_i) begin
            emit_err = 1'b1;
            emit_pc  = exp_wpc_q;
            state_d  = StHalt;
          end else if (bus.word_i[1:0] == 2'b11) begin
            emit_instr = bus.word_i;
            emit_pc    = bus.word_pc_i;
            exp_wpc_d  = exp_wpc_q + XLEN'(4);
          end else begin
            emit_instr = {16'h0, bus.word_i[15:0]};
            emit_pc    = bus.word_pc_i;
            emit_comp  = 1'b1;
            hw_d       = bus.word_i[31:16];
            exp_wpc_d  = exp_wpc_q + XLEN'(4);
            state_d    = StHalf;
          end
        end
      end
      StHalf: begin
        if (hw_comp) begin
          // Drain the held compressed halfword before taking another word.
          if (adv) begin
            emit       = 1'b1;
            emit_instr = {16'h0, hw_q};
            emit_pc    = hw_pc;
            emit_comp  = 1'b1;
            state_d    = StAligned;
          end
        end else begin
          word_ready = adv;
          take       = bus.word_valid_i & word_ready & word_match;
          if (take) begin
            emit = 1'b1;
            if (bus.word_err_i) begin
              emit_err = 1'b1;
              emit_pc  = hw_pc;
              state_d  = StHalt;
            end else begin
              emit_instr = {bus.word_i[15:0], hw_q};
              emit_pc    = hw_pc;
              hw_d       = bus.word_i[31:16];
              exp_wpc_d  = exp_wpc_q + XLEN'(4);
            end
          end
        end
      end
      StSkip: begin
        // Always ready, except a faulting word must wait until the slot can take the error.
        word_ready = ~(bus.word_valid_i & word_match & bus.word_err_i & ~adv);
        take       = bus.word_valid_i & word_ready & word_match;
        if (take) begin
          if (bus.word_err_i) begin
            emit     = 1'b1;
            emit_err = 1'b1;
            emit_pc  = exp_wpc_q;
            state_d  = StHalt;
          end else begin
            hw_d      = bus.word_i[31:16];
            exp_wpc_d = exp_wpc_q + XLEN'(4);
            state_d   = StHalf;
          end
        end
      end
      StHalt: begin
        word_ready = 1'b1;
      end
      default: ;
    endcase
`else
    unique case (state_q)
      StAligned: begin
        word_ready = adv;
        take       = bus.word_valid_i & word_ready & word_match;
        if (take) begin
          emit = 1'b1;
          if (bus.word_err_i || (bus.word_i[1:0] != 2'b11)) begin
            emit_err = 1'b1;
            emit_pc  = exp_wpc_q;
            state_d  = StHalt;
          end else begin
            emit_instr = bus.word_i;
            emit_pc    = bus.word_pc_i;
            exp_wpc_d  = exp_wpc_q + XLEN'(4);
          end
        end
      end
      StMisalign: begin
        // Redirect to a halfword PC cannot be executed without compressed support.
        if (adv) begin
          emit     = 1'b1;
          emit_err = 1'b1;
          emit_pc  = exp_wpc_q + XLEN'(2);
          state_d  = StHalt;
        end
      end
      StHalt: begin
        word_ready = 1'b1;
      end
      default: ;
    endcase
`endif

    if (emit) begin
      instr_valid_d = 1'b1;
      instr_d       = emit_instr;
      instr_pc_d    = emit_pc;
      instr_err_d   = emit_err;
`ifdef ALIGN_COMP_EN
      instr_comp_d  = emit_comp;
`endif
    end

    if (bus.redirect_i) begin
      word_ready    = 1'b0;
      instr_valid_d = 1'b0;
      exp_wpc_d     = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
`ifdef ALIGN_COMP_EN
      state_d       = bus.redirect_pc_i[1] ? StSkip : StAligned;
`else
      state_d       = bus.redirect_pc_i[1] ? StMisalign : StAligned;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StAligned;
      exp_wpc_q     <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_err_q   <= 1'b0;
`ifdef ALIGN_COMP_EN
      instr_comp_q  <= 1'b0;
      hw_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      exp_wpc_q     <= exp_wpc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_err_q   <= instr_err_d;
`ifdef ALIGN_COMP_EN
      instr_comp_q  <= instr_comp_d;
      hw_q          <= hw_d;
`endif
    end
  end

  assign bus.word_ready_o  = word_ready;
  assign bus.instr_valid_o = instr_valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign bus.instr_err_o   = instr_err_q;
`ifdef ALIGN_COMP_EN
  assign bus.instr_comp_o  = instr_comp_q;
`else
  assign bus.instr_comp_o  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_align_buffer.sv
// Bench for instr_align_buffer: directed cycle vectors for the corner cases, then random fetch
// traffic checked against a halfword-stream model.
module tb_instr_align_buffer;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_align_buffer_if #(.XLEN(32)) bus ();

  instr_align_buffer #(
    .XLEN    (32),
    .RESET_PC(32'h8000_0000)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        wv;
    logic [31:0] w;
    logic [31:0] wpc;
    logic        werr;
    logic        rd;
    logic [31:0] rpc;
    logic        ir;
    logic        e_wr;
    logic        e_iv;
    logic [31:0] e_i;
    logic [31:0] e_pc;
    logic        e_c;
    logic        e_e;
  } vec_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  vec_t        vecs[$];
  logic [15:0] hwq[$];
  exp_t        expq[$];
  logic [31:0] parse_pc;

  function automatic vec_t mk(input logic wv, input logic [31:0] w, input logic [31:0] wpc,
                              input logic werr, input logic rd, input logic [31:0] rpc,
                              input logic ir, input logic e_wr, input logic e_iv,
                              input logic [31:0] e_i, input logic [31:0] e_pc, input logic e_c,
                              input logic e_e);
    vec_t v;
    v = '{wv: wv, w: w, wpc: wpc, werr: werr, rd: rd, rpc: rpc, ir: ir, e_wr: e_wr, e_iv: e_iv,
          e_i: e_i, e_pc: e_pc, e_c: e_c, e_e: e_e};
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: instructions are carved from the in-order halfword stream of matching words.
  task automatic parse();
    while (hwq.size() > 0) begin
      if (hwq[0][1:0] != 2'b11) begin
        expq.push_back('{i: {16'h0, hwq[0]}, pc: parse_pc, c: 1'b1});
        void'(hwq.pop_front());
        parse_pc += 32'd2;
      end else if (hwq.size() >= 2) begin
        expq.push_back('{i: {hwq[1], hwq[0]}, pc: parse_pc, c: 1'b0});
        void'(hwq.pop_front());
        void'(hwq.pop_front());
        parse_pc += 32'd4;
      end else begin
        break;
      end
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] model_wpc;
    logic [31:0] cur_w;
    logic [31:0] cur_pc;
    logic        have;
    logic        stale;
    logic        hold;
    logic [66:0] held;
    int          sent;
    exp_t        e;

    bus.word_valid_i  = 1'b0;
    bus.word_i        = '0;
    bus.word_pc_i     = '0;
    bus.word_err_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;
    rst_n             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_valid", 72'(bus.instr_valid_o), 72'(0));
    check("reset_outputs", {bus.instr_comp_o, bus.instr_err_o, bus.instr_o, bus.instr_pc_o}, '0);

    // Columns: wv w wpc werr rd rpc ir | word_ready valid instr pc comp err
    vecs.push_back(mk(1, 32'h0000_0013, 32'h8000_0000, 0, 0, 0, 1, 1, 1, 32'h0000_0013, 32'h8000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0093, 32'h8000_0004, 0, 0, 0, 1, 1, 1, 32'h0000_0093, 32'h8000_0004, 0, 0));
`ifdef ALIGN_COMP_EN
    vecs.push_back(mk(1, 32'h0001_4501, 32'h8000_0008, 0, 0, 0, 1, 1, 1, 32'h0000_4501, 32'h8000_0008, 1, 0));
    vecs.push_back(mk(1, 32'h0013_4501, 32'h8000_000C, 0, 0, 0, 1, 0, 1, 32'h0000_0001, 32'h8000_000A, 1, 0));
    vecs.push_back(mk(1, 32'h0013_4501, 32'h8000_000C, 0, 0, 0, 1, 1, 1, 32'h0000_4501, 32'h8000_000C, 1, 0));
    vecs.push_back(mk(1, 32'h0000_0000, 32'h8000_0010, 0, 0, 0, 1, 1, 1, 32'h0000_0013, 32'h8000_000E, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 32'h0000_0000, 32'h8000_0012, 1, 0));
    vecs.push_back(mk(1, 32'h0000_0013, 32'h8000_0014, 0, 1, 32'h8000_0106, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1234_5678, 32'h8000_0008, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4505_0000, 32'h8000_0104, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 32'h0000_4505, 32'h8000_0106, 1, 0));
`else
    vecs.push_back(mk(1, 32'h0001_4501, 32'h8000_0008, 0, 0, 0, 1, 1, 1, 32'h0, 32'h8000_0008, 0, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 1, 32'h8000_0106, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4505_0000, 32'h8000_0104, 0, 0, 0, 1, 0, 1, 32'h0, 32'h8000_0106, 0, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 1, 32'h8000_0108, 1, 0, 0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk(1, 32'h0000_0033, 32'h8000_0108, 0, 0, 0, 1, 1, 1, 32'h0000_0033, 32'h8000_0108, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 32'h0000_0073, 32'h8000_010C, 0, 0, 0, 0, 0, 1, 32'h0000_0033, 32'h8000_0108, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0073, 32'h8000_010C, 0, 0, 0, 1, 1, 1, 32'h0000_0073, 32'h8000_010C, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 1, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0013, 32'h8000_0000, 1, 0, 0, 1, 1, 1, 32'h0, 32'h8000_0000, 0, 1));
    vecs.push_back(mk(1, 32'h0000_0093, 32'h8000_0004, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 1, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0013, 32'h8000_0000, 0, 0, 0, 1, 1, 1, 32'h0000_0013, 32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0093, 32'h0000_0000, 0, 0, 0, 1, 1, 1, 32'h0000_0093, 32'h0000_0000, 0, 0));

    foreach (vecs[k]) begin
      v                 = vecs[k];
      bus.word_valid_i  = v.wv;
      bus.word_i        = v.w;
      bus.word_pc_i     = v.wpc;
      bus.word_err_i    = v.werr;
      bus.redirect_i    = v.rd;
      bus.redirect_pc_i = v.rpc;
      bus.instr_ready_i = v.ir;
      @(negedge clk);
      check($sformatf("v%0d_word_ready", k), 72'(bus.word_ready_o), 72'(v.e_wr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_instr_valid", k), 72'(bus.instr_valid_o), 72'(v.e_iv));
      if (v.e_iv)
        check($sformatf("v%0d_instr_data", k),
              {bus.instr_comp_o, bus.instr_err_o, bus.instr_o, bus.instr_pc_o},
              {v.e_c, v.e_e, v.e_i, v.e_pc});
    end

    // Random traffic from a fresh aligned start, with stalls, gaps and stale words.
    bus.word_valid_i  = 1'b0;
    bus.word_err_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h4000_0000;
    bus.instr_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_i = 1'b0;
    model_wpc      = 32'h4000_0000;
    parse_pc       = 32'h4000_0000;
    have           = 1'b0;
    stale          = 1'b0;
    hold           = 1'b0;
    held           = '0;
    cur_w          = '0;
    cur_pc         = '0;
    sent           = 0;
    for (int cyc = 0; cyc < 4000 && !(sent >= 300 && expq.size() == 0); cyc++) begin
      if (!have && sent < 300) begin
        stale = ($urandom_range(0, 9) == 0);
        cur_w = $urandom;
`ifndef ALIGN_COMP_EN
        cur_w[1:0] = 2'b11;
`endif
        cur_pc = stale ? (model_wpc ^ 32'h0000_0100) : model_wpc;
        have   = 1'b1;
      end
      bus.word_valid_i  = have && ($urandom_range(0, 4) != 0);
      bus.word_i        = cur_w;
      bus.word_pc_i     = cur_pc;
      bus.instr_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (hold)
        check("rand_hold_stable", {bus.instr_valid_o, bus.instr_comp_o, bus.instr_err_o,
                                   bus.instr_o, bus.instr_pc_o}, held);
      hold = bus.instr_valid_o & ~bus.instr_ready_i;
      held = {bus.instr_valid_o, bus.instr_comp_o, bus.instr_err_o, bus.instr_o, bus.instr_pc_o};
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand_extra_instr: got %h @%h expected none", bus.instr_o, bus.instr_pc_o);
        end else begin
          e = expq.pop_front();
          check("rand_instr", {bus.instr_o, bus.instr_pc_o, bus.instr_comp_o, bus.instr_err_o},
                {e.i, e.pc, e.c, 1'b0});
        end
      end
      if (bus.word_valid_i && bus.word_ready_o) begin
        if (!stale) begin
          hwq.push_back(cur_w[15:0]);
          hwq.push_back(cur_w[31:16]);
          model_wpc += 32'd4;
          parse();
          sent++;
        end
        have = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check("rand_words_sent", 72'(sent), 72'(300));
    check("rand_drained", 72'(expq.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_align_buffer.md
Name: instr_align_buffer

Overview:
Sits directly downstream of the prefetch stage, between it and decode. Consumes word-aligned 32-bit fetch words tagged with their PC. Emits one instruction per cycle, either 32-bit or 16-bit compressed, with its exact halfword PC. Carries a leftover upper halfword across words, drops stale words after a redirect, and holds the output in a one-entry registered slot under valid/ready.

Parameters:
XLEN, 32, datapath and PC width.
RESET_PC, 32'h8000_0000, expected fetch PC out of reset.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
word_valid_i  in  1  fetch word available
word_ready_o  out  1  block consumes the word this cycle
word_i  in  32  fetch word
word_pc_i  in  32  word address; bits [1:0] always 00
word_err_i  in  1  fetch fault attached to this word
redirect_i  in  1  flush and restart at redirect_pc_i
redirect_pc_i  in  32  new PC; bit 0 ignored
instr_valid_o  out  1  output slot holds an instruction
instr_ready_i  in  1  decode accepts the slot
instr_o  out  32  instruction; compressed is zero-extended in [15:0]
instr_pc_o  out  32  PC of instr_o
instr_comp_o  out  1  instr_o is 16-bit
instr_err_o  out  1  fetch fault; instr_o = 0

Behaviour:
- Reset: state S_ALIGNED; exp_wpc = RESET_PC; hw_q = 0; all outputs 0.
- Definitions:
  - adv = ~instr_valid_o | instr_ready_i.
  - acc = word_valid_i & word_ready_o.
  - A word matches when word_pc_i == exp_wpc.
  - A halfword h is compressed when h[1:0] != 2'b11.
- On acc, a non-matching word is consumed and discarded: no emit, no state change.
- Emitting loads the output slot at the clock edge; it then takes one cycle to appear.
- If the slot is accepted (instr_ready_i=1) with no new emit, instr_valid_o clears.
- S_ALIGNED, word_ready_o = adv. On a matching word:
  - word[1:0]==11: emit word at PC word_pc; exp_wpc += 4.
  - Otherwise: emit {16'h0, word[15:0]}, comp=1; hw_q = word[31:16], hw_pc = word_pc+2; exp_wpc += 4; go to S_HALF.
- S_HALF, hw_q compressed:
  - word_ready_o = 0.
  - If adv: emit hw_q, comp=1, PC hw_pc; go to S_ALIGNED.
- S_HALF, hw_q 32-bit:
  - word_ready_o = adv.
  - On a matching word: emit {word[15:0], hw_q} at hw_pc; hw_q = word[31:16], hw_pc = word_pc+2; exp_wpc += 4; stay in S_HALF.
- S_SKIP, entered after a redirect to a halfword PC:
  - word_ready_o = 1.
  - On a matching word: hw_q = word[31:16], hw_pc = word_pc+2; exp_wpc += 4; go to S_HALF; no emit (one bubble).
- Error: a matching word with word_err_i=1, in a state that would consume it:
  - If adv: emit instr_o=0, err=1, comp=0, PC = exp_wpc, or hw_pc when in S_HALF; go to S_HALT.
  - If not adv: word_ready_o is 0, so the word waits.
- S_HALT: word_ready_o = 1; words are discarded; no emit until a redirect.
- Redirect (highest priority, same edge):
  - Clear instr_valid_o; exp_wpc = {redirect_pc_i[31:2], 2'b00}.
  - Go to S_SKIP if redirect_pc_i[1], else S_ALIGNED.
  - A word accepted in the same cycle is dropped.
  - word_ready_o is 0 during the redirect cycle.
- PC arithmetic is modulo 2^32; exp_wpc wraps from FFFF_FFFC to 0000_0000.
- Outputs are stable while instr_valid_o=1 and instr_ready_i=0.
- Steady-state throughput is one instruction per cycle.
- Latency is 1 cycle from word acceptance to instr_valid_o.

Optional Feature:
ALIGN_COMP_EN.
- Defined: compressed handling as above.
- Undefined:
  - S_HALF and S_SKIP are removed; every matching word is emitted as 32-bit and instr_comp_o is tied to 0.
  - A redirect with redirect_pc_i[1]=1 emits err=1 at that PC on the next adv cycle, then goes to S_HALT.
  - A word with word[1:0]!=11 emits err=1 at its PC.

Test Plan:
- Reset, then words 8000_0000: 0000_0013 and 8000_0004: 0000_0093 with ready=1 -> emits 0000_0013 @8000_0000 then 0000_0093 @8000_0004, comp=0, one per cycle.
- Word 8000_0000: 0001_4501 -> emits 0000_4501 @8000_0000 comp=1, then 0000_0001 @8000_0002 comp=1 with word_ready_o=0 during the second cycle.
- Words 8000_0000: 0013_4501 and 8000_0004: 0000_0000 -> second instruction 0000_0013 @8000_0002 comp=0, spanning both words.
- Redirect to 8000_0106, then stale word @8000_0008 followed by 8000_0104: 4505_0000 -> stale word dropped; emits 0000_4505 @8000_0106 comp=1.
- Hold instr_ready_i=0 for 3 cycles with words pending -> outputs stable; word_ready_o=0; no words lost.
- Word @8000_0000 with word_err_i=1 -> emits err=1, instr_o=0 @8000_0000; later words are discarded until redirect to 8000_0000.
